// File: rtl/activity_envelope_mc_if.sv
// Sample-in / level-out bundle for the multi-channel activity envelope tracker.
// Master drives samples and control, slave (the tracker) returns levels, peaks and clip flags.
interface activity_envelope_mc_if #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 24,
  parameter int OUT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     sample_valid_i;
  logic [CH_W-1:0]          sample_ch_i;
  logic signed [IN_W-1:0]   sample_i;
  logic                     mode_i;
  logic                     clip_clr_i;
  logic [NUM_CH*OUT_W-1:0]  level_o;
  logic [NUM_CH*OUT_W-1:0]  peak_o;
  logic                     level_valid_o;
  logic [CH_W-1:0]          level_ch_o;
  logic [NUM_CH-1:0]        clip_o;

  modport master (
    output sample_valid_i, sample_ch_i, sample_i, mode_i, clip_clr_i,
    input  level_o, peak_o, level_valid_o, level_ch_o, clip_o
  );

  modport slave (
    input  sample_valid_i, sample_ch_i, sample_i, mode_i, clip_clr_i,
    output level_o, peak_o, level_valid_o, level_ch_o, clip_o
  );
endinterface

// File: rtl/activity_envelope_mc.sv
// Per-channel activity envelope (leaky integrator or attack/release follower) with
// saturated level, timed peak hold and sticky clip flags; two-stage pipeline.
module activity_envelope_mc #(
  parameter int NUM_CH        = 2,
  parameter int IN_W          = 24,
  parameter int OUT_W         = 8,
  parameter int ACC_W         = 32,
  parameter int IN_SHIFT      = 8,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 10,
  parameter int SCALE_SHIFT   = 12,
  parameter int HOLD_SAMPLES  = 4800
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  activity_envelope_mc_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int EW     = ACC_W + 1;
  localparam int TW     = IN_W + RELEASE_SHIFT + ACC_W;
  localparam logic signed [IN_W-1:0] POS_FS = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] NEG_FS = {1'b1, {(IN_W-1){1'b0}}};

  function automatic logic [IN_W-1:0] abs_sat(input logic signed [IN_W-1:0] s);
    if (s == NEG_FS) return POS_FS;
    if (s < 0)       return $unsigned(-s);
    return $unsigned(s);
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [EW-1:0] v);
    return v[ACC_W] ? {ACC_W{1'b1}} : v[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] sat_target(input logic [TW-1:0] v);
    return (|v[TW-1:ACC_W]) ? {ACC_W{1'b1}} : v[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] to_level(input logic [ACC_W-1:0] e);
    logic [ACC_W-1:0] sh;
    sh = e >> SCALE_SHIFT;
    if (|sh[ACC_W-1:OUT_W]) return {OUT_W{1'b1}};
    return sh[OUT_W-1:0];
  endfunction

  logic [ACC_W-1:0]  env_q   [NUM_CH];
  logic [OUT_W-1:0]  level_q [NUM_CH];
  logic [OUT_W-1:0]  peak_q  [NUM_CH];
  logic [HOLD_W-1:0] hold_q  [NUM_CH];
  logic [NUM_CH-1:0] clip_q, clip_nxt;

  // ---- stage p0: accept sample, compute new envelope and clip flags
  logic              vld_p0;
  logic [CH_W-1:0]   ch_p0;
  logic [IN_W-1:0]   mag_p0;
  logic [EW-1:0]     env_p0, x_p0, tgt_p0, sum_p0;
  logic [ACC_W-1:0]  env_nxt_p0;

  assign ch_p0  = bus.sample_ch_i;
  assign vld_p0 = bus.sample_valid_i && (32'(bus.sample_ch_i) < NUM_CH);
  assign mag_p0 = abs_sat(bus.sample_i);

  always_comb begin
    env_p0 = {1'b0, env_q[ch_p0]};
    x_p0   = EW'(mag_p0 >> IN_SHIFT);
    tgt_p0 = {1'b0, sat_target(TW'(mag_p0 >> IN_SHIFT) << RELEASE_SHIFT)};
    if (!bus.mode_i)
      sum_p0 = env_p0 - (env_p0 >> RELEASE_SHIFT) + x_p0;
    else if (tgt_p0 > env_p0)
      sum_p0 = env_p0 + ((tgt_p0 - env_p0) >> ATTACK_SHIFT);
    else
      sum_p0 = env_p0 - ((env_p0 - tgt_p0) >> RELEASE_SHIFT);
    env_nxt_p0 = sat_acc(sum_p0);
  end

  // A set on the sampled channel overrides a simultaneous clear.
  always_comb begin
    clip_nxt = clip_q & ~{NUM_CH{bus.clip_clr_i}};
    if (vld_p0 && (bus.sample_i == POS_FS || bus.sample_i == NEG_FS))
      clip_nxt[ch_p0] = 1'b1;
  end

  logic            vld_p1;
  logic [CH_W-1:0] ch_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) env_q[c] <= '0;
      clip_q <= '0;
      vld_p1 <= 1'b0;
      ch_p1  <= '0;
    end else begin
      if (vld_p0) env_q[ch_p0] <= env_nxt_p0;
      clip_q <= clip_nxt;
      vld_p1 <= vld_p0;
      ch_p1  <= ch_p0;
    end
  end

  // ---- stage p1: level, peak hold and output pulse from the freshly written envelope
  logic [OUT_W-1:0]  lvl_p1, peak_cur_p1, peak_nxt_p1;
  logic [HOLD_W-1:0] hold_cur_p1, hold_nxt_p1;
  logic              level_valid_q;
  logic [CH_W-1:0]   level_ch_q;

  always_comb begin
    lvl_p1      = to_level(env_q[ch_p1]);
    peak_cur_p1 = peak_q[ch_p1];
    hold_cur_p1 = hold_q[ch_p1];
    peak_nxt_p1 = peak_cur_p1;
    hold_nxt_p1 = hold_cur_p1;
    if (lvl_p1 >= peak_cur_p1) begin
      peak_nxt_p1 = lvl_p1;
      hold_nxt_p1 = HOLD_W'(HOLD_SAMPLES);
    end else if (hold_cur_p1 != '0) begin
      hold_nxt_p1 = hold_cur_p1 - HOLD_W'(1);
    end else begin
      peak_nxt_p1 = ((peak_cur_p1 - OUT_W'(1)) > lvl_p1) ? (peak_cur_p1 - OUT_W'(1)) : lvl_p1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        level_q[c] <= '0;
        peak_q[c]  <= '0;
        hold_q[c]  <= '0;
      end
      level_valid_q <= 1'b0;
      level_ch_q    <= '0;
    end else begin
      if (vld_p1) begin
        level_q[ch_p1] <= lvl_p1;
        peak_q[ch_p1]  <= peak_nxt_p1;
        hold_q[ch_p1]  <= hold_nxt_p1;
        level_ch_q     <= ch_p1;
      end
      level_valid_q <= vld_p1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign bus.level_o[c*OUT_W +: OUT_W] = level_q[c];
    assign bus.peak_o[c*OUT_W +: OUT_W]  = peak_q[c];
  end

  assign bus.clip_o        = clip_q;
  assign bus.level_valid_o = level_valid_q;
  assign bus.level_ch_o    = level_ch_q;
endmodule

// File: tb/tb_activity_envelope_mc.sv
// Directed self-checking bench for activity_envelope_mc: a 2-channel instance for the
// main behaviour and a 3-channel instance for out-of-range channel rejection.
module tb_activity_envelope_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  activity_envelope_mc_if #(.NUM_CH(2)) if2 ();
  activity_envelope_mc_if #(.NUM_CH(3)) if3 ();

  activity_envelope_mc #(.NUM_CH(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
  activity_envelope_mc #(.NUM_CH(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3));

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lvl2(input int c);
    return int'(if2.level_o[c*8 +: 8]);
  endfunction
  function automatic int pk2(input int c);
    return int'(if2.peak_o[c*8 +: 8]);
  endfunction
  function automatic int lvl3(input int c);
    return int'(if3.level_o[c*8 +: 8]);
  endfunction

  task automatic drive2(input logic v, input logic c, input logic [23:0] s, input logic m);
    if2.sample_valid_i = v;
    if2.sample_ch_i    = c;
    if2.sample_i       = s;
    if2.mode_i         = m;
  endtask

  task automatic drive3(input logic v, input logic [1:0] c, input logic [23:0] s, input logic m);
    if3.sample_valid_i = v;
    if3.sample_ch_i    = c;
    if3.sample_i       = s;
    if3.mode_i         = m;
  endtask

  // One isolated sample: returns just after E1, when its level pulse is visible.
  task automatic send2(input logic c, input logic [23:0] s, input logic m);
    drive2(1'b1, c, s, m);
    step();
    if2.sample_valid_i = 1'b0;
    step();
  endtask

  int prev, l, pk, hold, cnt_hold;
  int pat2 [5] = '{0, 1, 1, 0, 1};
  int pat3 [5] = '{0, 1, 3, 2, 0};

  initial begin
    drive2(1'b0, 1'b0, 24'h0, 1'b0);
    drive3(1'b0, 2'd0, 24'h0, 1'b0);
    if2.clip_clr_i = 1'b0;
    if3.clip_clr_i = 1'b0;
    repeat (3) step();

    check_eq("rst_level", if2.level_o, 0);
    check_eq("rst_peak", if2.peak_o, 0);
    check_eq("rst_clip", if2.clip_o, 0);
    check_eq("rst_valid", if2.level_valid_o, 0);
    check_eq("rst_ch", if2.level_ch_o, 0);
    rst_n = 1'b1;
    step();

    // Attack ramp, mode 1, ch0, x=64 -> target 65536; env 16384, 28672, 37888, 44800 ...
    send2(1'b0, 24'h004000, 1'b1);
    check_eq("ramp_valid", if2.level_valid_o, 1);
    check_eq("ramp_ch", if2.level_ch_o, 0);
    check_eq("ramp_l1", lvl2(0), 4);
    check_eq("ramp_ch1_idle", lvl2(1), 0);
    send2(1'b0, 24'h004000, 1'b1);
    check_eq("ramp_l2", lvl2(0), 7);
    send2(1'b0, 24'h004000, 1'b1);
    check_eq("ramp_l3", lvl2(0), 9);
    send2(1'b0, 24'h004000, 1'b1);
    check_eq("ramp_l4", lvl2(0), 10);
    prev = lvl2(0);
    drive2(1'b1, 1'b0, 24'h004000, 1'b1);
    for (int i = 0; i < 62; i++) begin
      if (i == 60) if2.sample_valid_i = 1'b0;
      step();
      if (if2.level_valid_o) begin
        check_eq("ramp_monotonic", (lvl2(0) >= prev) ? 1 : 0, 1);
        prev = lvl2(0);
      end
    end
    // Shift truncation stalls the follower 3 LSBs below target: env 65533 -> level 15.
    check_eq("ramp_final", lvl2(0), 15);
    check_eq("ramp_peak", pk2(0), 15);
    check_eq("ramp_ch1_lvl", lvl2(1), 0);
    check_eq("ramp_ch1_peak", pk2(1), 0);

    // Release with peak hold: input 0 on ch0, one sample per cycle.
    pk = 15; hold = 4800; cnt_hold = 0;
    drive2(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 5002; i++) begin
      if (i == 5000) if2.sample_valid_i = 1'b0;
      step();
      if (if2.level_valid_o) begin
        l = lvl2(0);
        if (l >= pk) begin
          pk = l; hold = 4800;
        end else if (hold > 0) begin
          hold--;
        end else begin
          pk = (pk - 1 > l) ? pk - 1 : l;
        end
        check_eq("hold_peak", pk2(0), pk);
        if (l < 15 && pk2(0) == 15) cnt_hold++;
      end
    end
    check_eq("hold_count", cnt_hold, 4800);
    check_eq("hold_end_peak", pk2(0), 0);
    check_eq("hold_end_level", lvl2(0), 0);

    // Leaky integrator, ch1 full scale: x=32767 -> env 32767, 65503, ... saturating level.
    send2(1'b1, 24'h7FFFFF, 1'b0);
    check_eq("leaky_l1", lvl2(1), 7);
    check_eq("leaky_clip", if2.clip_o, 2);
    send2(1'b1, 24'h7FFFFF, 1'b0);
    check_eq("leaky_l2", lvl2(1), 15);
    drive2(1'b1, 1'b1, 24'h7FFFFF, 1'b0);
    repeat (64) step();
    if2.sample_valid_i = 1'b0;
    step(); step();
    check_eq("leaky_sat", lvl2(1), 255);
    check_eq("leaky_peak", pk2(1), 255);
    check_eq("leaky_ch0_hold", lvl2(0), 0);
    if2.clip_clr_i = 1'b1;
    step();
    if2.clip_clr_i = 1'b0;
    check_eq("clr_lone", if2.clip_o, 0);

    // Reset asserted between edges while samples are streaming.
    drive2(1'b1, 1'b0, 24'h7FFFFF, 1'b0);
    step(); step();
    check_eq("pre_rst_valid", if2.level_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_level", if2.level_o, 0);
    check_eq("mid_rst_peak", if2.peak_o, 0);
    check_eq("mid_rst_clip", if2.clip_o, 0);
    check_eq("mid_rst_valid", if2.level_valid_o, 0);
    step();
    check_eq("rst_edge_valid", if2.level_valid_o, 0);
    if2.sample_valid_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive2(1'b1, 1'b0, 24'h004000, 1'b1);
    step();
    check_eq("post_rst_e0", if2.level_valid_o, 0);
    if2.sample_valid_i = 1'b0;
    step();
    check_eq("post_rst_e1", if2.level_valid_o, 1);
    check_eq("post_rst_lvl", lvl2(0), 4);

    // Most negative sample: clip on ch1, magnitude 0x7FFFFF (level 7, not 8).
    drive2(1'b1, 1'b1, 24'h800000, 1'b0);
    step();
    check_eq("clip_neg_e0", if2.clip_o, 2);
    if2.sample_valid_i = 1'b0;
    step();
    check_eq("clip_neg_abs", lvl2(1), 7);
    send2(1'b0, 24'h7FFFFF, 1'b0);
    check_eq("clip_both", if2.clip_o, 3);
    drive2(1'b1, 1'b1, 24'h800000, 1'b0);
    if2.clip_clr_i = 1'b1;
    step();
    check_eq("clip_set_wins", if2.clip_o, 2);
    if2.sample_valid_i = 1'b0;
    step();
    check_eq("clip_clr_held", if2.clip_o, 0);
    if2.clip_clr_i = 1'b0;

    // Interleaved channels every cycle: channel tags follow input order, 2 edges late.
    for (int k = 0; k < 7; k++) begin
      if (k < 5) drive2(1'b1, pat2[k][0], 24'h004000, 1'b1);
      else       if2.sample_valid_i = 1'b0;
      step();
      check_eq("il2_valid", if2.level_valid_o, (k >= 1 && k <= 5) ? 1 : 0);
      if (k >= 1 && k <= 5) check_eq("il2_ch", if2.level_ch_o, pat2[k-1]);
    end

    // Three-channel instance: index 3 is out of range and must leave no trace.
    for (int k = 0; k < 7; k++) begin
      if (k < 5) drive3(1'b1, pat3[k][1:0], (pat3[k] == 3) ? 24'h7FFFFF : 24'h004000, 1'b1);
      else       if3.sample_valid_i = 1'b0;
      step();
      check_eq("il3_valid", if3.level_valid_o, (k >= 1 && k <= 5 && pat3[(k >= 1) ? k-1 : 0] != 3) ? 1 : 0);
      if (k >= 1 && k <= 5 && pat3[k-1] != 3) check_eq("il3_ch", if3.level_ch_o, pat3[k-1]);
    end
    check_eq("oor_clip", if3.clip_o, 0);
    check_eq("il3_lvl0", lvl3(0), 7);
    check_eq("il3_lvl1", lvl3(1), 4);
    check_eq("il3_lvl2", lvl3(2), 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
